// File: rtl/shift_register_en.sv
// shift_register_en: serial-in / parallel-out shift register with clock enable.
//
// Parameters
//   WIDTH       register length in bits (legal 2..64)
//   RESET_VALUE contents loaded while rst is low
//   SHIFT_LEFT  1: d enters q[0] and data moves toward q[WIDTH-1]
//               0: d enters q[WIDTH-1] and data moves toward q[0]
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   en    shift enable, sampled on rising clk
//   d     serial data in
//   q     parallel contents, driven straight from the flops
//   sout  (only with SHIFT_REGISTER_EN_SOUT_EN defined) registered copy of
//         the bit pushed off the far end at each enabled shift; resets to 0
//
// Optional feature macro: SHIFT_REGISTER_EN_SOUT_EN
module shift_register_en #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter bit                    SHIFT_LEFT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
`ifdef SHIFT_REGISTER_EN_SOUT_EN
  ,
  output logic             sout
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shifted;

  // Direction is fixed at elaboration; only one shifter is built.
  generate
    if (SHIFT_LEFT) begin : g_left
      assign shifted = {q_q[WIDTH-2:0], d};
    end else begin : g_right
      assign shifted = {d, q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (en) q_d = shifted;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RESET_VALUE;
    else      q_q <= q_d;
  end

  assign q = q_q;

`ifdef SHIFT_REGISTER_EN_SOUT_EN
  logic sout_q, sout_d;
  logic far_bit;

  // The bit about to fall off the register on the next enabled shift.
  assign far_bit = SHIFT_LEFT ? q_q[WIDTH-1] : q_q[0];

  always_comb begin
    sout_d = sout_q;
    if (en) sout_d = far_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sout_q <= 1'b0;
    else      sout_q <= sout_d;
  end

  assign sout = sout_q;
`endif

endmodule

// File: tb/tb_shift_register_en.sv
// Scoreboard bench for shift_register_en: two 8-bit instances (left and
// right shifting) share stimulus. Each stimulus step pushes hand-computed
// expectations; a monitor pops and compares on the falling clock edge.
module tb_shift_register_en;

  logic       clk;
  logic       rst;
  logic       en;
  logic       d;
  logic [7:0] q_l;
  logic [7:0] q_r;
`ifdef SHIFT_REGISTER_EN_SOUT_EN
  logic       sout_l;
  logic       sout_r;
`endif

  shift_register_en #(.WIDTH(8), .RESET_VALUE(8'h00), .SHIFT_LEFT(1'b1)) u_left (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q_l)
`ifdef SHIFT_REGISTER_EN_SOUT_EN
    ,
    .sout(sout_l)
`endif
  );

  shift_register_en #(.WIDTH(8), .RESET_VALUE(8'h00), .SHIFT_LEFT(1'b0)) u_right (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .q   (q_r)
`ifdef SHIFT_REGISTER_EN_SOUT_EN
    ,
    .sout(sout_r)
`endif
  );

  // Clock starts high so the first falling edge (t=10) precedes any rising edge.
  initial clk = 1'b1;
  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] el;
    logic [7:0] er;
    logic       esl;
    logic       esr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: one expectation is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk8({e.name, ".q_left"},  q_l, e.el);
        chk8({e.name, ".q_right"}, q_r, e.er);
`ifdef SHIFT_REGISTER_EN_SOUT_EN
        chk1({e.name, ".sout_left"},  sout_l, e.esl);
        chk1({e.name, ".sout_right"}, sout_r, e.esr);
`endif
      end
    end
  end

  task automatic push(input string nm, input logic [7:0] el, input logic [7:0] er,
                      input logic esl, input logic esr);
    exp_t e;
    e.name = nm; e.el = el; e.er = er; e.esl = esl; e.esr = esr;
    sb.push_back(e);
  endtask

  // One clock step. glitch drives the opposite en value first and settles it
  // well before the rising edge, so only the settled value may count.
  task automatic step(input logic r, input logic e, input logic dd, input logic glitch,
                      input logic [7:0] el, input logic [7:0] er,
                      input logic esl, input logic esr, input string nm);
    @(negedge clk);
    #1;
    rst = r;
    d   = dd;
    en  = glitch ? ~e : e;
    if (glitch) begin
      #4;
      en = e;
    end
    @(posedge clk);
    #1;
    push(nm, el, er, esl, esr);
  endtask

  // Hold for one edge, then drop rst halfway to the next falling edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    push(nm, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b0;
    en  = 1'b0;
    d   = 1'b0;
    push("reset_t0", 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset held while en/d active: nothing moves.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "rst_active_en");

    // First shifts after release.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h80, 1'b0, 1'b0, "shift_d1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h40, 1'b0, 1'b0, "shift_d0");
    // en low with d toggling, plus en pulses between edges.
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 8'h40, 1'b0, 1'b0, "hold_d1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h40, 1'b0, 1'b0, "hold_d0");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h20, 1'b0, 1'b0, "shift_to_04");

    // Mid-stream asynchronous reset, then reset held across an enabled edge.
    async_reset("async_rst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "rst_hold_edge");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h80, 1'b0, 1'b0, "after_rst");

    // Keep d=1 for 8 more edges: full after edge 8, sout picks up 1 at edge 9.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 8'hC0, 1'b0, 1'b0, "fill2");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 8'hE0, 1'b0, 1'b0, "fill3");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0, 1'b0, 1'b0, "fill4");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h1F, 8'hF8, 1'b0, 1'b0, "fill5");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h3F, 8'hFC, 1'b0, 1'b0, "fill6");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 8'hFE, 1'b0, 1'b0, "fill7");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, "fill8");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, "fill9");

    // Drain with zeros: far-end bits are discarded, no wrap-around.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h7F, 1'b1, 1'b1, "drain1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFC, 8'h3F, 1'b1, 1'b1, "drain2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFC, 8'h3F, 1'b1, 1'b1, "hold_full");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hF9, 8'h9F, 1'b1, 1'b1, "mix1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hF2, 8'h4F, 1'b1, 1'b1, "mix0");

    // Reset also clears sout.
    async_reset("async_rst_full");

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_register_en.md
SHIFT_REGISTER_EN -- requirements
Module: shift_register_en

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 8 and set the register length in bits; legal range is 2..64.
REQ-003 Parameter RESET_VALUE SHALL default to all-zeros, be WIDTH bits, and give the register contents while reset is asserted.
REQ-004 Parameter SHIFT_LEFT SHALL default to 1: d enters q[0] and data moves toward q[WIDTH-1]; 0 SHALL mirror this (d enters q[WIDTH-1], data moves toward q[0]).
REQ-005 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port en SHALL be an input, 1 bit: shift enable, sampled on rising clk.
REQ-008 Port d SHALL be an input, 1 bit: serial data in.
REQ-009 Port q SHALL be an output, WIDTH bits: parallel register contents, driven directly from flops.

Function
REQ-010 On each rising clk edge with rst=1 and en=1, the register SHALL shift by one position.
- SHIFT_LEFT=1: q <= {q[WIDTH-2:0], d}.
- SHIFT_LEFT=0: q <= {d, q[WIDTH-1:1]}.
REQ-011 On a rising clk edge with rst=1 and en=0, q SHALL hold its value.
REQ-012 Latency: a d value sampled at edge N SHALL appear at the entry bit after edge N, and at the far-end bit after edge N+WIDTH-1 when en stays 1.
REQ-013 The bit shifted off the far end SHALL be discarded; there SHALL be no wrap-around.
REQ-014 X on en or d while rst=0 SHALL NOT affect q.
REQ-015 en toggling between edges SHALL have no effect; only the value at the rising edge counts.

Reset
REQ-016 rst falling to 0 SHALL force q to RESET_VALUE immediately, without waiting for a clock edge.
REQ-017 q SHALL stay at RESET_VALUE while rst=0, regardless of clk, en and d.
REQ-018 Reset asserted mid-stream SHALL discard all shifted data.
REQ-019 After rst rises, the first shift SHALL happen on the first rising clk edge at which rst=1 and en=1.
REQ-020 rst and a clk edge occurring together with rst=0 SHALL resolve to reset.

Configuration
REQ-021 Macro SHIFT_REGISTER_EN_SOUT_EN defined SHALL add output port sout, 1 bit, listed after q.
- sout SHALL register the bit discarded at each enabled shift: q[WIDTH-1] for SHIFT_LEFT=1, q[0] for SHIFT_LEFT=0.
- sout SHALL hold when en=0.
- sout SHALL reset to 0 asynchronously with rst.
REQ-022 Macro SHIFT_REGISTER_EN_SOUT_EN undefined SHALL mean sout and its flop are absent and the port list is exactly clk, rst, en, d, q.

Verification
REQ-023 Clock period 20 ns; rst=0, en=0, d=0 at t=0 -> q=8'h00 before any rising edge.
REQ-024 rst=1, en=1, d=1 sampled at one edge, then d=0 at the next -> q=8'h01, then 8'h02.
REQ-025 en=0 with d toggling over two edges -> q unchanged, e.g. holds 8'h02.
REQ-026 rst driven 0 between edges with q=8'h04 -> q=8'h00 immediately; after rst=1, en=1, d=1 at one edge -> q=8'h01.
REQ-027 en=1, d=1 held for 9 edges -> q=8'hFF after edge 8 and stays 8'hFF; with the macro defined, sout=1 after edge 9.
REQ-028 SHIFT_LEFT=0, d=1 for one edge then 0 -> q=8'h80, then 8'h40.
